// File: rtl/score_pkg.sv
// Shared constants and saturating arithmetic helpers
// for the multi-channel score tracker.
package score_pkg;

  localparam int STREAK_W     = 4;
  localparam int DEF_PLAYERS  = 2;
  localparam int DEF_SCORE_W  = 16;
  localparam int DEF_THRESH   = 5;
  localparam int DEF_BONUS    = 10;
  localparam int DEF_PENALTY  = 0;

  // One bit of headroom above the widest supported score (32).
  typedef logic [32:0] calc_t;

  function automatic calc_t sat_add(
    input calc_t a,
    input calc_t b,
    input calc_t max
  );
    calc_t s;
    s = a + b;
    return (s > max) ? max : s;
  endfunction

  function automatic calc_t sat_sub(
    input calc_t a,
    input calc_t b
  );
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/score_channel.sv
// Single score channel: score, hit streak, bonus strobe
// and miss penalty, all registered with latency 1.
module score_channel
  import score_pkg::*;
#(
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int BONUS_THRESH = DEF_THRESH,
  parameter int BONUS_POINTS = DEF_BONUS,
  parameter int MISS_PENALTY = DEF_PENALTY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                hit,
  input  logic                miss,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic                bonus
);

  localparam calc_t MAX_SC = (calc_t'(1) << SCORE_W) - calc_t'(1);
  localparam calc_t BON_SC = calc_t'(1 + BONUS_POINTS);
  localparam calc_t PEN_SC = calc_t'(MISS_PENALTY);
  localparam logic [STREAK_W:0] THR = (STREAK_W+1)'(BONUS_THRESH);

  logic [SCORE_W-1:0]  r_score;
  logic [STREAK_W-1:0] r_streak;
  logic                r_bonus;

  calc_t               w_cur;
  calc_t               w_score_nx;
  logic [STREAK_W-1:0] w_streak_nx;
  logic                w_bonus_nx;
  logic                w_at_thr;

  assign w_cur    = calc_t'(r_score);
  assign w_at_thr = ({1'b0, r_streak} + 1'b1) == THR;

  // Next-state: a miss overrides a simultaneous hit.
  always_comb begin
    w_score_nx  = w_cur;
    w_streak_nx = r_streak;
    w_bonus_nx  = 1'b0;
    if (miss) begin
      w_streak_nx = '0;
      w_score_nx  = sat_sub(w_cur, PEN_SC);
    end else if (hit) begin
      if (w_at_thr) begin
        w_streak_nx = '0;
        w_score_nx  = sat_add(w_cur, BON_SC, MAX_SC);
        w_bonus_nx  = 1'b1;
      end else begin
        w_streak_nx = r_streak + 1'b1;
        w_score_nx  = sat_add(w_cur, calc_t'(1), MAX_SC);
      end
    end
  end

  // Channel state; clear discards same-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score  <= '0;
      r_streak <= '0;
      r_bonus  <= 1'b0;
    end else if (clear) begin
      r_score  <= '0;
      r_streak <= '0;
      r_bonus  <= 1'b0;
    end else begin
      r_score  <= w_score_nx[SCORE_W-1:0];
      r_streak <= w_streak_nx;
      r_bonus  <= w_bonus_nx;
    end
  end

  assign score  = r_score;
  assign streak = r_streak;
  assign bonus  = r_bonus;

endmodule

// File: rtl/multi_score_tracker.sv
// N independent score channels plus a registered
// leader / all-time high-score stage (latency 2).
module multi_score_tracker
  import score_pkg::*;
#(
  parameter int N_PLAYERS    = DEF_PLAYERS,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int BONUS_THRESH = DEF_THRESH,
  parameter int BONUS_POINTS = DEF_BONUS,
  parameter int MISS_PENALTY = DEF_PENALTY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [N_PLAYERS-1:0]          hit_pulse,
  input  logic [N_PLAYERS-1:0]          miss_pulse,
  output logic [N_PLAYERS*SCORE_W-1:0]  score,
  output logic [N_PLAYERS*STREAK_W-1:0] streak,
  output logic [N_PLAYERS-1:0]          bonus_pulse,
  output logic [SCORE_W-1:0]            high_score,
  output logic [2:0]                    leader
);

  logic [N_PLAYERS*SCORE_W-1:0] w_score;
  logic [SCORE_W-1:0]           w_max;
  logic [2:0]                   w_best;
  logic [SCORE_W-1:0]           r_high;
  logic [2:0]                   r_leader;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_ch
    score_channel #(
      .SCORE_W      (SCORE_W),
      .BONUS_THRESH (BONUS_THRESH),
      .BONUS_POINTS (BONUS_POINTS),
      .MISS_PENALTY (MISS_PENALTY)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .hit    (hit_pulse[g]),
      .miss   (miss_pulse[g]),
      .score  (w_score[g*SCORE_W +: SCORE_W]),
      .streak (streak[g*STREAK_W +: STREAK_W]),
      .bonus  (bonus_pulse[g])
    );
  end

  // Max over registered scores; strict > keeps lowest tied index.
  always_comb begin
    w_max  = w_score[SCORE_W-1:0];
    w_best = 3'd0;
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (w_score[i*SCORE_W +: SCORE_W] > w_max) begin
        w_max  = w_score[i*SCORE_W +: SCORE_W];
        w_best = 3'(i);
      end
    end
  end

  // Leader and monotonic high score; clear leaves high alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_leader <= 3'd0;
      r_high   <= '0;
    end else begin
      r_leader <= clear ? 3'd0 : w_best;
      if (w_max > r_high) begin
        r_high <= w_max;
      end
    end
  end

  assign score      = w_score;
  assign high_score = r_high;
  assign leader     = r_leader;

endmodule

// File: tb/tb_multi_score_tracker.sv
// Randomised + directed bench for multi_score_tracker
// against an arithmetic reference model (two configs).
module tb_multi_score_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic [1:0]  hA = '0, mA = '0;
  logic [2:0]  hB = '0, mB = '0;

  logic [31:0] scA;
  logic [7:0]  stA;
  logic [1:0]  bnA;
  logic [15:0] hiA;
  logic [2:0]  ldA;

  logic [23:0] scB;
  logic [11:0] stB;
  logic [2:0]  bnB;
  logic [7:0]  hiB;
  logic [2:0]  ldB;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_score_tracker u_a (
    .clk(clk), .rst(rst), .clear(clr),
    .hit_pulse(hA), .miss_pulse(mA),
    .score(scA), .streak(stA), .bonus_pulse(bnA),
    .high_score(hiA), .leader(ldA)
  );

  multi_score_tracker #(
    .N_PLAYERS(3), .SCORE_W(8), .BONUS_THRESH(5),
    .BONUS_POINTS(10), .MISS_PENALTY(3)
  ) u_b (
    .clk(clk), .rst(rst), .clear(clr),
    .hit_pulse(hB), .miss_pulse(mB),
    .score(scB), .streak(stB), .bonus_pulse(bnB),
    .high_score(hiB), .leader(ldB)
  );

  // Reference model: [dut][channel]
  int NP[2]  = '{2, 3};
  int W[2]   = '{16, 8};
  int TH[2]  = '{5, 5};
  int BP[2]  = '{10, 10};
  int PEN[2] = '{0, 3};
  int ms[2][8];
  int mt[2][8];
  int mb[2][8];
  int mh[2];
  int ml[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0;
      ml[d] = 0;
      for (int i = 0; i < 8; i++) begin
        ms[d][i] = 0; mt[d][i] = 0; mb[d][i] = 0;
      end
    end
  endtask

  task automatic model_edge(input int d, input logic [7:0] h,
                            input logic [7:0] m, input bit c);
    int best;
    int mx;
    best = 0;
    mx = (1 << W[d]) - 1;
    for (int i = 1; i < NP[d]; i++)
      if (ms[d][i] > ms[d][best]) best = i;
    if (ms[d][best] > mh[d]) mh[d] = ms[d][best];
    ml[d] = c ? 0 : best;
    for (int i = 0; i < NP[d]; i++) begin
      mb[d][i] = 0;
      if (c) begin
        ms[d][i] = 0; mt[d][i] = 0;
      end else if (m[i]) begin
        mt[d][i] = 0;
        ms[d][i] = ms[d][i] - PEN[d];
        if (ms[d][i] < 0) ms[d][i] = 0;
      end else if (h[i]) begin
        if (mt[d][i] + 1 == TH[d]) begin
          mt[d][i] = 0;
          ms[d][i] = ms[d][i] + 1 + BP[d];
          mb[d][i] = 1;
        end else begin
          mt[d][i] = mt[d][i] + 1;
          ms[d][i] = ms[d][i] + 1;
        end
        if (ms[d][i] > mx) ms[d][i] = mx;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("A.score%0d", i), 64'(scA[i*16 +: 16]), 64'(ms[0][i]));
      chk($sformatf("A.streak%0d", i), 64'(stA[i*4 +: 4]), 64'(mt[0][i]));
      chk($sformatf("A.bonus%0d", i), 64'(bnA[i]), 64'(mb[0][i]));
    end
    chk("A.high", 64'(hiA), 64'(mh[0]));
    chk("A.leader", 64'(ldA), 64'(ml[0]));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("B.score%0d", i), 64'(scB[i*8 +: 8]), 64'(ms[1][i]));
      chk($sformatf("B.streak%0d", i), 64'(stB[i*4 +: 4]), 64'(mt[1][i]));
      chk($sformatf("B.bonus%0d", i), 64'(bnB[i]), 64'(mb[1][i]));
    end
    chk("B.high", 64'(hiB), 64'(mh[1]));
    chk("B.leader", 64'(ldB), 64'(ml[1]));
  endtask

  // Drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input logic [1:0] ha, input logic [1:0] ma,
                     input logic [2:0] hb, input logic [2:0] mbb,
                     input bit c);
    hA = ha; mA = ma; hB = hb; mB = mbb; clr = c;
    @(posedge clk);
    model_edge(0, 8'(ha), 8'(ma), c);
    model_edge(1, 8'(hb), 8'(mbb), c);
    @(negedge clk);
    hA = '0; mA = '0; hB = '0; mB = '0; clr = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    hA = 2'b11; hB = 3'b111;
    repeat (2) @(negedge clk);
    check_all();
    hA = '0; hB = '0;
    rst = 1'b0;

    // Five hits on A ch0: 1,2,3,4,15 with bonus on the fifth
    for (int k = 0; k < 5; k++) begin
      cyc(2'b01, 2'b00, 3'b000, 3'b000, 1'b0);
      chk("A.seq40", 64'(scA[15:0]), (k == 4) ? 64'd15 : 64'(k + 1));
      chk("A.bon40", 64'(bnA[0]), (k == 4) ? 64'd1 : 64'd0);
    end
    chk("A.stk40", 64'(stA[3:0]), 64'd0);
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    chk("A.high15", 64'(hiA), 64'd15);

    // Hit then hit+miss together on A (no penalty)
    cyc(2'b01, 2'b00, 3'b000, 3'b000, 1'b0);
    cyc(2'b01, 2'b01, 3'b000, 3'b000, 1'b0);
    chk("A.hm_score", 64'(scA[15:0]), 64'd16);
    chk("A.hm_streak", 64'(stA[3:0]), 64'd0);

    // Penalty floors at zero on B ch1
    cyc(2'b00, 2'b00, 3'b010, 3'b000, 1'b0);
    cyc(2'b00, 2'b00, 3'b010, 3'b000, 1'b0);
    cyc(2'b00, 2'b00, 3'b000, 3'b010, 1'b0);
    chk("B.floor", 64'(scB[15:8]), 64'd0);
    cyc(2'b00, 2'b00, 3'b010, 3'b010, 1'b0);

    // Tie at 7 on A -> leader 0, then ch1 pulls ahead
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 3'b000, 3'b000, 1'b0);
    cyc(2'b00, 2'b11, 3'b000, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) cyc(2'b11, 2'b00, 3'b000, 3'b000, 1'b0);
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    chk("A.tie_ld", 64'(ldA), 64'd0);
    cyc(2'b10, 2'b00, 3'b000, 3'b000, 1'b0);
    chk("A.ld_hold", 64'(ldA), 64'd0);
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    chk("A.ld_new", 64'(ldA), 64'd1);

    // Clear with a hit: hit discarded, high score kept
    cyc(2'b11, 2'b00, 3'b111, 3'b000, 1'b1);
    chk("A.clr_s0", 64'(scA[15:0]), 64'd0);
    chk("A.clr_hi", 64'(hiA), 64'd16);
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b0);

    // Drive B ch0 into saturation at 255
    for (int k = 0; k < 160; k++)
      cyc(2'b00, 2'b00, 3'b001, 3'b000, 1'b0);
    chk("B.sat", 64'(scB[7:0]), 64'd255);

    // Random traffic on both configurations
    for (int k = 0; k < 400; k++) begin
      cyc(2'($urandom), ($urandom % 4 == 0) ? 2'($urandom) : 2'b00,
          3'($urandom), ($urandom % 4 == 0) ? 3'($urandom) : 3'b000,
          ($urandom % 50 == 0));
    end

    // Async reset mid-streak (A ch0 streak 3)
    cyc(2'b00, 2'b00, 3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) cyc(2'b01, 2'b00, 3'b001, 3'b000, 1'b0);
    chk("A.stk3", 64'(stA[3:0]), 64'd3);
    hA = 2'b01; hB = 3'b001;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    hA = '0; hB = '0;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(2'b01, 2'b00, 3'b000, 3'b000, 1'b0);
      chk("A.rst_bon", 64'(bnA[0]), (k == 4) ? 64'd1 : 64'd0);
    end
    chk("A.rst_sc", 64'(scA[15:0]), 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_score_tracker.md
MULTI_SCORE_TRACKER -- requirements
Module: multi_score_tracker

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of independent score channels, 1..8.
REQ-002 Parameter SCORE_W, default 16: score width per channel, in bits.
REQ-003 Parameter BONUS_THRESH, default 5: consecutive hits that earn a bonus, 2..15.
REQ-004 Parameter BONUS_POINTS, default 10: extra points on a bonus hit.
REQ-005 Parameter MISS_PENALTY, default 0: points subtracted per miss; 0 disables the penalty.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 clear  input  1  synchronous round clear.
REQ-009 hit_pulse  input  N_PLAYERS  one-cycle hit strobe per channel.
REQ-010 miss_pulse  input  N_PLAYERS  one-cycle miss strobe per channel.
REQ-011 score  output  N_PLAYERS*SCORE_W  packed scores; channel i occupies bits [i*SCORE_W +: SCORE_W].
REQ-012 streak  output  N_PLAYERS*4  packed current streak counts; channel i occupies bits [i*4 +: 4].
REQ-013 bonus_pulse  output  N_PLAYERS  one-cycle strobe per channel when a bonus is awarded.
REQ-014 high_score  output  SCORE_W  highest score reached since reset.
REQ-015 leader  output  3  index of the channel currently holding the maximum score.

Function
REQ-016 Each channel SHALL update on the clk edge that samples its strobes, so its score, streak and bonus_pulse are valid in the next cycle (latency 1).
REQ-017 On a hit with streak+1 < BONUS_THRESH, the channel SHALL add 1 to score and increment streak.
REQ-018 On a hit with streak+1 == BONUS_THRESH, the channel SHALL add 1+BONUS_POINTS to score, set streak to 0 and assert bonus_pulse for one cycle.
REQ-019 On a miss, the channel SHALL set streak to 0 and subtract MISS_PENALTY from score, flooring at 0.
REQ-020 When hit and miss are asserted together on one channel, the miss SHALL take effect and the hit SHALL be ignored.
REQ-021 Score addition SHALL saturate at 2^SCORE_W-1 and never wrap; the streak and bonus_pulse behaviour SHALL be unchanged by saturation.
REQ-022 Arithmetic SHALL use at least SCORE_W+1 bits internally before clamping.
REQ-023 Channels SHALL be fully independent; simultaneous strobes on any mix of channels SHALL all be applied in the same cycle.
REQ-024 leader SHALL be computed from the registered scores and registered once more, giving latency 2 from the strobe.
REQ-025 When scores tie, leader SHALL report the lowest tied index.
REQ-026 high_score SHALL be updated from the registered scores with latency 2 from the strobe.
REQ-027 high_score SHALL never decrease, including across clear.
REQ-028 clear SHALL zero every score, streak, bonus_pulse and leader on the next edge.
REQ-029 clear SHALL take priority over strobes in the same cycle, and those strobes SHALL be discarded.
REQ-030 clear SHALL leave high_score unchanged.
REQ-031 A strobe held high for k cycles SHALL count as k events.

Reset
REQ-032 rst SHALL asynchronously force score, streak, bonus_pulse, high_score and leader to 0.
REQ-033 Strobes that arrive during reset SHALL be ignored.
REQ-034 Reset asserted mid-streak SHALL lose the streak, so the first hit after release starts at streak 1.
REQ-035 The first clk edge after rst deasserts SHALL sample strobes normally.

Structure
REQ-036 The shared package score_pkg SHALL hold the streak width constant (4), the default parameter values and the saturating add/subtract helper functions.
REQ-037 One sub-module, score_channel, SHALL implement a single channel's score, streak, bonus and penalty logic.
REQ-038 The top level SHALL instantiate N_PLAYERS copies of score_channel through a generate loop and add the leader and high-score stage.
REQ-039 The top level SHALL contain no latches and no combinational paths from input to output.

Verification
REQ-040 Five hits on channel 0 with defaults -> score0 = 1,2,3,4,15; bonus_pulse0 high on the fifth update only; streak0 = 0.
REQ-041 MISS_PENALTY=3, score1=2, miss on channel 1 -> score1 = 0 and streak1 = 0; a hit and a miss in the same cycle -> score unchanged and streak = 0.
REQ-042 SCORE_W=8, score = 250, a bonus hit -> score = 255 and bonus_pulse asserted; a further hit -> score stays 255.
REQ-043 Channel 0 and channel 1 both reach 7 -> leader = 0; one more hit on channel 1 -> leader = 1 two cycles later.
REQ-044 high_score = 15, then clear asserted together with a hit -> all scores 0, hit discarded, high_score stays 15.
REQ-045 rst asserted asynchronously mid-cycle at streak 3 -> all outputs 0 immediately; after release, 5 hits are needed for the next bonus.
